mult_8x8_quad_sched: RTL and testbench

MULT_8X8_QUAD_SCHED -- requirements
Module: mult_8x8_quad_sched

---
 rtl/mult_8x8_quad_sched_if.sv | 31 +++
 rtl/mult_8x8_quad_sched.sv | 153 +++++++++++++++
 tb/tb_mult_8x8_quad_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_8x8_quad_sched_if.sv
// Handshake and shared-multiplier bus for mult_8x8_quad_sched.
// The slave modport is the scheduler's view. The master modport is the
// requester/consumer/multiplier side.
interface mult_8x8_quad_sched_if #(
  parameter int unsigned CNT_W = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [7:0]       A;
  logic [7:0]       B;
  logic             MODE;
  logic             M_EN;
  logic [1:0]       M_SEL;
  logic [3:0]       MA;
  logic [3:0]       MB;
  logic [7:0]       MR;
  logic [15:0]      R;
  logic             R_VALID;
  logic             R_READY;
  logic [CNT_W-1:0] OPS_CNT;

  modport slave (
    input  IN_VALID, A, B, MODE, MR, R_READY,
    output IN_READY, M_EN, M_SEL, MA, MB, R, R_VALID, OPS_CNT
  );

  modport master (
    output IN_VALID, A, B, MODE, MR, R_READY,
    input  IN_READY, M_EN, M_SEL, MA, MB, R, R_VALID, OPS_CNT
  );
endinterface

// File: rtl/mult_8x8_quad_sched.sv
// 8x8 multiplier built from four time-multiplexed passes through an external
// shared 4x4 unit. The partial products are merged exactly (add) or
// approximately (OR). Results are handed off with a valid/ready handshake,
// and consumed results are counted.
module mult_8x8_quad_sched #(
  parameter int unsigned CNT_W = 16
) (
  input logic                      clk,
  input logic                      rst,
  mult_8x8_quad_sched_if.slave     bus
);

  typedef enum logic [2:0] {
    StIdle,
    StQ0,
    StQ1,
    StQ2,
    StQ3,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             mode_q, mode_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             m_en;
  logic [1:0]       m_sel;
  logic [3:0]       ma;
  logic [3:0]       mb;
  logic [15:0]      r;
  logic             r_valid;
  logic [15:0]      part;

  // Next-state, quadrant scheduling, accumulation and output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    m_en     = 1'b0;
    m_sel    = 2'd0;
    ma       = 4'd0;
    mb       = 4'd0;
    r        = 16'd0;
    r_valid  = 1'b0;
    part     = 16'd0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (bus.IN_VALID) begin
          a_d     = bus.A;
          b_d     = bus.B;
          mode_d  = bus.MODE;
          acc_d   = 16'd0;
          state_d = StQ0;
        end
      end
      StQ0: begin
        m_en    = 1'b1;
        m_sel   = 2'd0;
        ma      = a_q[3:0];
        mb      = b_q[3:0];
        part    = {8'd0, bus.MR};
        state_d = StQ1;
      end
      StQ1: begin
        m_en    = 1'b1;
        m_sel   = 2'd1;
        ma      = a_q[3:0];
        mb      = b_q[7:4];
        part    = {4'd0, bus.MR, 4'd0};
        state_d = StQ2;
      end
      StQ2: begin
        m_en    = 1'b1;
        m_sel   = 2'd2;
        ma      = a_q[7:4];
        mb      = b_q[3:0];
        part    = {4'd0, bus.MR, 4'd0};
        state_d = StQ3;
      end
      StQ3: begin
        m_en    = 1'b1;
        m_sel   = 2'd3;
        ma      = a_q[7:4];
        mb      = b_q[7:4];
        part    = {bus.MR, 8'd0};
        state_d = StDone;
      end
      StDone: begin
        r        = acc_q;
        r_valid  = 1'b1;
        // A new request can only slip in when the current result leaves.
        in_ready = bus.R_READY;
        if (bus.R_READY) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.IN_VALID) begin
            a_d     = bus.A;
            b_d     = bus.B;
            mode_d  = bus.MODE;
            acc_d   = 16'd0;
            state_d = StQ0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // In Q states, merge the shifted partial product into the accumulator.
    if (m_en) begin
      acc_d = mode_q ? (acc_q | part) : (acc_q + part);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      mode_q  <= 1'b0;
      acc_q   <= 16'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.M_EN     = m_en;
  assign bus.M_SEL    = m_sel;
  assign bus.MA       = ma;
  assign bus.MB       = mb;
  assign bus.R        = r;
  assign bus.R_VALID  = r_valid;
  assign bus.OPS_CNT  = cnt_q;

endmodule

// File: tb/tb_mult_8x8_quad_sched.sv
// Scoreboard bench for mult_8x8_quad_sched. It uses an exact 4x4 multiplier
// model on the shared bus. A second instance with a 2-bit counter exercises
// wraparound.
module tb_mult_8x8_quad_sched;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  mult_8x8_quad_sched_if #(.CNT_W(16)) bus ();
  mult_8x8_quad_sched #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.MR = {4'd0, bus.MA} * {4'd0, bus.MB};

  mult_8x8_quad_sched_if #(.CNT_W(2)) bus2 ();
  mult_8x8_quad_sched #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
  assign bus2.MR = {4'd0, bus2.MA} * {4'd0, bus2.MB};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic [15:0] exp_r;
    int          acc_cyc;
  } op_t;

  op_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [15:0] cnt_model = 16'd0;
  bit          b2b = 1'b0;
  int          last_acc = -1;
  bit          done2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, or the OR of the four shifted nibble products.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic m);
    int al, ah, bl, bh;
    al = int'(a[3:0]);
    ah = int'(a[7:4]);
    bl = int'(b[3:0]);
    bh = int'(b[7:4]);
    if (!m) return 16'(int'(a) * int'(b));
    return 16'((al * bl) | ((al * bh) << 4) | ((ah * bl) << 4) | ((ah * bh) << 8));
  endfunction

  // Issue one request as soon as IN_READY allows and record its expectation.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.IN_READY && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.IN_READY) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    bus.IN_VALID = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.MODE     = m;
    @(posedge clk);
    #1;
    sb.push_back('{a: a, b: b, mode: m, exp_r: ref_mul(a, b, m), acc_cyc: cyc});
    if (b2b && last_acc >= 0) check("b2b_period", cyc - last_acc, 5);
    last_acc = cyc;
    // Scramble operands to show the capture is isolated from later changes.
    bus.IN_VALID = 1'b0;
    bus.A        = 8'($urandom);
    bus.B        = 8'($urandom);
    bus.MODE     = 1'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_done", sb.size(), 0);
    check("ops_cnt_after_drain", bus.OPS_CNT, cnt_model);
  endtask

  // Monitor: quadrant bus, latency, result and counter, decoupled from stimulus.
  initial begin
    int   q_cnt;
    logic rv_prev;
    op_t  op;
    q_cnt   = 0;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q_cnt     = 0;
        rv_prev   = 1'b0;
        cnt_model = 16'd0;
      end else begin
        if (bus.M_EN) begin
          if (sb.size() == 0) begin
            check("m_en_without_op", 1, 0);
          end else begin
            op = sb[0];
            check("m_sel", bus.M_SEL, q_cnt);
            check("ma", bus.MA, (q_cnt < 2) ? op.a[3:0] : op.a[7:4]);
            check("mb", bus.MB, (q_cnt % 2 == 0) ? op.b[3:0] : op.b[7:4]);
          end
          q_cnt = (q_cnt + 1) % 4;
        end else begin
          check("mbus_idle_zero", {bus.M_SEL, bus.MA, bus.MB}, 0);
        end
        if (!bus.R_VALID) check("r_zero_when_invalid", bus.R, 0);
        if (bus.R_VALID && !rv_prev && sb.size() != 0) begin
          // Acceptance edge plus four more edges: the fifth edge raises R_VALID.
          check("latency", cyc - sb[0].acc_cyc, 4);
        end
        if (bus.R_VALID && bus.R_READY) begin
          if (sb.size() == 0) begin
            check("result_without_op", 1, 0);
          end else begin
            op = sb.pop_front();
            check("result_r", bus.R, op.exp_r);
            check("ops_cnt_at_consume", bus.OPS_CNT, cnt_model);
            cnt_model = cnt_model + 16'd1;
          end
        end
        rv_prev = bus.R_VALID;
      end
    end
  end

  // Counter wraparound on a 2-bit instance, fed back-to-back.
  initial begin
    int k;
    rst2          = 1'b1;
    bus2.IN_VALID = 1'b1;
    bus2.R_READY  = 1'b1;
    bus2.A        = 8'h5A;
    bus2.B        = 8'hC3;
    bus2.MODE     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int n = 0; n < 5; n++) begin
      k = 0;
      @(negedge clk);
      while (!bus2.R_VALID && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!bus2.R_VALID) begin
        check("w2_timeout", 0, 1);
      end else begin
        check("w2_result", bus2.R, ref_mul(8'h5A, 8'hC3, 1'b0));
        @(posedge clk);
        #1;
        check("w2_ops_cnt", bus2.OPS_CNT, (n + 1) % 4);
      end
    end
    done2 = 1'b1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    logic [15:0] r0;
    logic [15:0] c0;
    int          k;
    rst          = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.A        = 8'd0;
    bus.B        = 8'd0;
    bus.MODE     = 1'b0;
    bus.R_READY  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_r", bus.R, 0);
    check("rst_r_valid", bus.R_VALID, 0);
    check("rst_m_en", bus.M_EN, 0);
    check("rst_mbus", {bus.M_SEL, bus.MA, bus.MB}, 0);
    check("rst_ops_cnt", bus.OPS_CNT, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("idle_in_ready", bus.IN_READY, 1);

    // Directed values.
    send(8'hFF, 8'hFF, 1'b0);
    drain();
    check("ff_ff_add_cnt", bus.OPS_CNT, 1);
    send(8'hFF, 8'hFF, 1'b1);
    send(8'h12, 8'h34, 1'b1);
    send(8'h12, 8'h34, 1'b0);
    drain();
    check("known_value_0368", ref_mul(8'h12, 8'h34, 1'b1), 16'h0368);
    check("known_value_eff1", ref_mul(8'hFF, 8'hFF, 1'b1), 16'hEFF1);

    // Back-pressure: hold the result for three cycles.
    bus.R_READY = 1'b0;
    send(8'hA7, 8'h3C, 1'b0);
    k = 0;
    @(negedge clk);
    while (!bus.R_VALID && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid_seen", bus.R_VALID, 1);
    r0 = bus.R;
    c0 = bus.OPS_CNT;
    repeat (3) begin
      @(negedge clk);
      check("bp_r_stable", bus.R, r0);
      check("bp_r_valid", bus.R_VALID, 1);
      check("bp_in_ready", bus.IN_READY, 0);
      check("bp_ops_cnt", bus.OPS_CNT, c0);
    end
    @(posedge clk);
    #1 bus.R_READY = 1'b1;
    drain();
    check("bp_cnt_once", bus.OPS_CNT, c0 + 16'd1);

    // Back-to-back stream.
    b2b      = 1'b1;
    last_acc = -1;
    repeat (8) send(8'($urandom), 8'($urandom), 1'($urandom));
    b2b = 1'b0;
    drain();

    // Reset in Q2 abandons the operation.
    send(8'h9D, 8'h62, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("q2_m_sel", bus.M_SEL, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("q2rst_r_valid", bus.R_VALID, 0);
    check("q2rst_m_en", bus.M_EN, 0);
    check("q2rst_ops_cnt", bus.OPS_CNT, 0);
    void'(sb.pop_front());
    rst = 1'b0;
    #1 check("q2rst_in_ready", bus.IN_READY, 1);
    send(8'h12, 8'h34, 1'b0);
    drain();

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    drain();

    k = 0;
    while (!done2 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("w2_finished", done2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
